// File: rtl/q2_mem_arb.sv
// rtl/q2_mem_arb.sv - two-port (CPU/panel) round-robin arbiter onto one shared memory bus
// Optional output-port latch at 12'hFFF is built when Q2_ARB_OUTPUT_EN is defined.
module q2_mem_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [11:0] c_addr,
  input  logic [11:0] c_wdata,
  output logic [11:0] c_rdata,
  output logic        c_ack,
  input  logic        p_req,
  input  logic        p_we,
  input  logic [11:0] p_addr,
  input  logic [11:0] p_wdata,
  output logic [11:0] p_rdata,
  output logic        p_ack,
  output logic [11:0] abus,
  inout  wire  [11:0] dbus,
  output logic        rdm,
  output logic        wrm,
  output logic        busy,
  output logic [11:0] out_data,
  output logic        out_stb
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, ACK} state_t;

  state_t      state_q, state_d;
  logic        last_p_q, last_p_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [11:0] wdata_q, wdata_d;
  logic [11:0] c_rdata_q, c_rdata_d;
  logic [11:0] p_rdata_q, p_rdata_d;
  logic        pick_p;

  // last_p_q doubles as the grant id of the access in flight.
  always_comb begin
    state_d   = state_q;
    last_p_d  = last_p_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    c_rdata_d = c_rdata_q;
    p_rdata_d = p_rdata_q;
    pick_p    = p_req && (!c_req || !last_p_q);
    case (state_q)
      IDLE: begin
        if (c_req || p_req) begin
          last_p_d = pick_p;
          we_d     = pick_p ? p_we    : c_we;
          addr_d   = pick_p ? p_addr  : c_addr;
          wdata_d  = pick_p ? p_wdata : c_wdata;
          state_d  = SETUP;
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: begin
        state_d = ACK;
        if (!we_q) begin
          if (last_p_q) p_rdata_d = dbus;
          else          c_rdata_d = dbus;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_p_q  <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= 12'h000;
      wdata_q   <= 12'h000;
      c_rdata_q <= 12'h000;
      p_rdata_q <= 12'h000;
    end else begin
      state_q   <= state_d;
      last_p_q  <= last_p_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      c_rdata_q <= c_rdata_d;
      p_rdata_q <= p_rdata_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign abus    = busy ? addr_q : 12'h000;
  assign rdm     = !we_q && ((state_q == SETUP) || (state_q == STROBE));
  assign wrm     = we_q && (state_q == STROBE);
  assign dbus    = (busy && we_q) ? wdata_q : 12'bz;
  assign c_ack   = (state_q == ACK) && !last_p_q;
  assign p_ack   = (state_q == ACK) && last_p_q;
  assign c_rdata = c_rdata_q;
  assign p_rdata = p_rdata_q;

`ifdef Q2_ARB_OUTPUT_EN
  logic [11:0] out_data_q, out_data_d;
  logic        out_hit;

  assign out_hit = we_q && (addr_q == 12'hFFF);

  always_comb begin
    out_data_d = out_data_q;
    if ((state_q == STROBE) && out_hit) out_data_d = wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) out_data_q <= 12'h000;
    else     out_data_q <= out_data_d;
  end

  assign out_data = out_data_q;
  assign out_stb  = (state_q == ACK) && out_hit;
`else
  assign out_data = 12'h000;
  assign out_stb  = 1'b0;
`endif

endmodule

// File: tb/tb_q2_mem_arb.sv
// tb/tb_q2_mem_arb.sv - randomized + directed bench for q2_mem_arb against a transaction-level model
module tb_q2_mem_arb;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        c_req = 1'b0, c_we = 1'b0, p_req = 1'b0, p_we = 1'b0;
  logic [11:0] c_addr = '0, c_wdata = '0, p_addr = '0, p_wdata = '0;
  logic [11:0] c_rdata, p_rdata, abus, out_data;
  logic        c_ack, p_ack, rdm, wrm, busy, out_stb;
  wire  [11:0] dbus;

  logic [11:0] mem [4096];
  logic [11:0] ref_mem [4096];

  assign dbus = rdm ? mem[abus] : 12'bz;

  q2_mem_arb dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_rdata(c_rdata), .c_ack(c_ack),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata), .p_rdata(p_rdata), .p_ack(p_ack),
    .abus(abus), .dbus(dbus), .rdm(rdm), .wrm(wrm), .busy(busy),
    .out_data(out_data), .out_stb(out_stb)
  );

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [11:0] wdata;
  } txn_t;

  txn_t qc[$], qp[$];
  txn_t cur [2];
  bit   act [2];

  // Model: cycles elapsed since grant (0 = idle), winner, last winner, predicted registers.
  int          ph = 0;
  int          win = 0;
  bit          last_p = 1'b1;
  txn_t        g = '0;
  logic [11:0] exp_rd [2];
  logic [11:0] exp_out = '0;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    if (!act[0] && qc.size() > 0) begin cur[0] = qc.pop_front(); act[0] = 1'b1; end
    if (!act[1] && qp.size() > 0) begin cur[1] = qp.pop_front(); act[1] = 1'b1; end
    c_req = act[0]; c_we = cur[0].we; c_addr = cur[0].addr; c_wdata = cur[0].wdata;
    p_req = act[1]; p_we = cur[1].we; p_addr = cur[1].addr; p_wdata = cur[1].wdata;
  endtask

  task automatic sample_and_model();
    logic exp_stb;
    check("busy",  busy, 32'(ph != 0));
    check("abus",  abus, (ph != 0) ? 32'(g.addr) : 32'h0);
    check("rdm",   rdm,  32'((ph == 1 || ph == 2) && !g.we));
    check("wrm",   wrm,  32'(ph == 2 && g.we));
    check("c_ack", c_ack, 32'(ph == 3 && win == 0));
    check("p_ack", p_ack, 32'(ph == 3 && win == 1));
    check("c_rdata", c_rdata, exp_rd[0]);
    check("p_rdata", p_rdata, exp_rd[1]);
`ifdef Q2_ARB_OUTPUT_EN
    exp_stb = (ph == 3) && g.we && (g.addr == 12'hFFF);
    check("out_data", out_data, exp_out);
`else
    exp_stb = 1'b0;
    check("out_data", out_data, 32'h0);
`endif
    check("out_stb", out_stb, 32'(exp_stb));

    if (rst) begin
      // The write strobe has already risen if reset lands in the strobe cycle.
      if (ph == 2 && g.we) ref_mem[g.addr] = g.wdata;
      ph = 0; last_p = 1'b1; exp_rd[0] = '0; exp_rd[1] = '0; exp_out = '0;
    end else begin
      case (ph)
        0: if (act[0] || act[1]) begin
          win    = (act[1] && (!act[0] || !last_p)) ? 1 : 0;
          last_p = (win == 1);
          g      = cur[win];
          ph     = 1;
        end
        1: ph = 2;
        2: begin
          if (g.we) begin
            ref_mem[g.addr] = g.wdata;
`ifdef Q2_ARB_OUTPUT_EN
            if (g.addr == 12'hFFF) exp_out = g.wdata;
`endif
          end else begin
            exp_rd[win] = ref_mem[g.addr];
          end
          ph = 3;
        end
        default: begin
          act[win] = 1'b0;
          ph = 0;
        end
      endcase
    end
  endtask

  task automatic step(input bit do_rst);
    @(posedge clk);
    #1;
    rst = do_rst;
    drive();
    @(negedge clk);
    sample_and_model();
  endtask

  function automatic txn_t rnd_txn();
    txn_t t;
    t.we    = 1'($urandom);
    t.addr  = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
    t.wdata = 12'($urandom);
    return t;
  endfunction

  initial begin
    int k;
    logic [11:0] v;
    for (int i = 0; i < 4096; i++) begin
      v = 12'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[12'h123] = 12'hABC; ref_mem[12'h123] = 12'hABC;
    cur[0] = '0; cur[1] = '0; act[0] = 1'b0; act[1] = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;

    fork
      forever begin
        @(posedge wrm);
        mem[abus] = dbus;
      end
    join_none

    step(1); step(1); step(0);

    qc.push_back('{we: 1'b0, addr: 12'h123, wdata: 12'h000});
    repeat (6) step(0);
    check("cpu_read_123", c_rdata, 32'hABC);

    qp.push_back('{we: 1'b1, addr: 12'h010, wdata: 12'h5A5});
    repeat (6) step(0);
    check("mem_010", mem[12'h010], 32'h5A5);

    step(1);
    for (int i = 0; i < 3; i++) begin
      qc.push_back('{we: 1'b0, addr: 12'(12'h200 + i), wdata: 12'h000});
      qp.push_back('{we: 1'b1, addr: 12'(12'h300 + i), wdata: 12'(12'h0A0 + i)});
    end
    repeat (30) step(0);
    check("tie_drain", 32'(act[0] || act[1] || qc.size() != 0 || qp.size() != 0), 32'h0);

    qc.push_back('{we: 1'b1, addr: 12'h020, wdata: 12'h6B6});
    k = 0;
    while (ph != 2 && k < 10) begin step(0); k++; end
    check("reach_strobe", 32'(ph == 2), 32'h1);
    step(1);
    k = 0;
    while (act[0] && k < 20) begin step(0); k++; end
    check("retry_done", 32'(act[0]), 32'h0);
    check("mem_020", mem[12'h020], 32'h6B6);

    qc.push_back('{we: 1'b1, addr: 12'hFFF, wdata: 12'h07F});
    repeat (6) step(0);
    check("mem_fff", mem[12'hFFF], 32'h07F);
`ifdef Q2_ARB_OUTPUT_EN
    check("out_latch", out_data, 32'h07F);
`endif

    qc.push_back('{we: 1'b1, addr: 12'h040, wdata: 12'h321});
    qc.push_back('{we: 1'b0, addr: 12'h040, wdata: 12'h000});
    repeat (10) step(0);
    check("raw_040", c_rdata, 32'h321);

    for (int i = 0; i < 1500; i++) begin
      if (qc.size() == 0 && $urandom_range(0, 2) == 0) qc.push_back(rnd_txn());
      if (qp.size() == 0 && $urandom_range(0, 2) == 0) qp.push_back(rnd_txn());
      step($urandom_range(0, 199) == 0);
    end
    k = 0;
    while ((act[0] || act[1] || qc.size() != 0 || qp.size() != 0) && k < 100) begin step(0); k++; end
    check("final_drain", 32'(act[0] || act[1]), 32'h0);
    for (int a = 0; a < 16; a++) check("mem_final", mem[a], ref_mem[a]);
    check("mem_final_fff", mem[12'hFFF], ref_mem[12'hFFF]);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
